// File: rtl/spec_mem_tracker_pkg.sv
// Shared types and constants for the data-memory tracker.
// Each slot records one word-granule transaction seen on the LSU bus.
package spec_mem_tracker_pkg;

   localparam int unsigned GranuleBytes = 4;
   localparam int unsigned MemSlots     = 2;

   typedef struct packed {
      logic        valid;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } mem_slot_t;

   typedef enum logic [2:0] {
      StEmpty,
      StFstPend,
      StFstDone,
      StSndPend,
      StBothDone
   } mem_state_e;

   // Overlapping grants reach StSndPend without passing through StFstDone.
   function automatic mem_state_e mem_state(logic [1:0] req_cnt, logic [1:0] rsp_cnt);
      if (req_cnt == 2'd0) begin
         return StEmpty;
      end else if (req_cnt == 2'd1) begin
         return (rsp_cnt == 2'd0) ? StFstPend : StFstDone;
      end else begin
         return (rsp_cnt == 2'd2) ? StBothDone : StSndPend;
      end
   endfunction

endpackage

// File: rtl/spec_mem_slot.sv
// One captured granule: request fields on grant, response fields on rvalid.
// Clear applies first so a same-cycle capture lands in the emptied slot.
module spec_mem_slot
   import spec_mem_tracker_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        req_cap_i,
   input  logic        req_we_i,
   input  logic [3:0]  req_be_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic        rsp_cap_i,
   input  logic [31:0] rsp_rdata_i,
   input  logic        rsp_err_i,
   output mem_slot_t   slot_o
);

   mem_slot_t slot_d, slot_q;

   always_comb begin
      slot_d = slot_q;
      if (clear_i) begin
         slot_d = '0;
      end
      if (req_cap_i) begin
         slot_d.valid = 1'b1;
         slot_d.we    = req_we_i;
         slot_d.be    = req_be_i;
         slot_d.addr  = req_addr_i;
         slot_d.wdata = req_we_i ? req_wdata_i : 32'h0;
      end
      if (rsp_cap_i) begin
         slot_d.rdata = rsp_rdata_i;
         slot_d.err   = rsp_err_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;

endmodule

// File: rtl/spec_mem_tracker.sv
// Records up to two in-order data-memory transactions per instruction window
// and flags bus protocol violations with a sticky error.
module spec_mem_tracker
   import spec_mem_tracker_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned CheckGranule   = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        data_req_i,
   input  logic        data_gnt_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   input  logic        data_err_i,
   output logic        fst_valid_o,
   output logic        snd_valid_o,
   output logic        fst_we_o,
   output logic        snd_we_o,
   output logic [3:0]  fst_be_o,
   output logic [3:0]  snd_be_o,
   output logic [31:0] fst_addr_o,
   output logic [31:0] snd_addr_o,
   output logic [31:0] fst_wdata_o,
   output logic [31:0] snd_wdata_o,
   output logic [31:0] mem_read_fst_rdata_o,
   output logic [31:0] mem_read_snd_rdata_o,
   output logic        fst_err_o,
   output logic        snd_err_o,
   output logic        done_o,
   output logic        proto_err_o
);

   logic [1:0] req_cnt_d, req_cnt_q;
   logic [1:0] rsp_cnt_d, rsp_cnt_q;
   logic       proto_err_d, proto_err_q;
   logic [1:0] outstanding;
   logic       accept, gnt_ok, rsp_ok, viol;
   logic [1:0] req_cap, rsp_cap;
   logic [31:0] snd_addr_exp;
   mem_slot_t  fst, snd;
   mem_state_e state;

   assign outstanding  = req_cnt_q - rsp_cnt_q;
   assign accept       = data_req_i && data_gnt_i;
   assign snd_addr_exp = {fst.addr[31:2], 2'b00} + 32'(GranuleBytes);

   always_comb begin
      gnt_ok    = 1'b0;
      rsp_ok    = 1'b0;
      viol      = 1'b0;
      req_cap   = 2'b00;
      rsp_cap   = 2'b00;
      req_cnt_d = req_cnt_q;
      rsp_cnt_d = rsp_cnt_q;
      if (clear_i) begin
         // Window restarts: a concurrent grant becomes fst, a concurrent rvalid is dropped.
         gnt_ok     = accept;
         req_cap[0] = accept;
         req_cnt_d  = accept ? 2'd1 : 2'd0;
         rsp_cnt_d  = 2'd0;
         viol       = (outstanding != 2'd0);
      end else begin
         if (accept) begin
            if (req_cnt_q >= 2'(MemSlots)) begin
               viol = 1'b1;
            end else if (32'(outstanding) >= MaxOutstanding) begin
               viol = 1'b1;
            end else begin
               gnt_ok             = 1'b1;
               req_cap[req_cnt_q[0]] = 1'b1;
               if (req_cnt_q == 2'd1) begin
                  if ((CheckGranule != 0) && (data_addr_i != snd_addr_exp)) viol = 1'b1;
                  if (data_we_i != fst.we) viol = 1'b1;
               end
            end
         end
         // A zero-latency response to this cycle's grant is legal.
         if (data_rvalid_i) begin
            if ((outstanding != 2'd0) || gnt_ok) begin
               rsp_ok                = 1'b1;
               rsp_cap[rsp_cnt_q[0]] = 1'b1;
            end else begin
               viol = 1'b1;
            end
         end
         req_cnt_d = req_cnt_q + {1'b0, gnt_ok};
         rsp_cnt_d = rsp_cnt_q + {1'b0, rsp_ok};
      end
      proto_err_d = proto_err_q | viol;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_cnt_q   <= 2'd0;
         rsp_cnt_q   <= 2'd0;
         proto_err_q <= 1'b0;
      end else begin
         req_cnt_q   <= req_cnt_d;
         rsp_cnt_q   <= rsp_cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

   spec_mem_slot u_fst (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .req_cap_i   (req_cap[0]),
      .req_we_i    (data_we_i),
      .req_be_i    (data_be_i),
      .req_addr_i  (data_addr_i),
      .req_wdata_i (data_wdata_i),
      .rsp_cap_i   (rsp_cap[0]),
      .rsp_rdata_i (data_rdata_i),
      .rsp_err_i   (data_err_i),
      .slot_o      (fst)
   );

   spec_mem_slot u_snd (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .req_cap_i   (req_cap[1]),
      .req_we_i    (data_we_i),
      .req_be_i    (data_be_i),
      .req_addr_i  (data_addr_i),
      .req_wdata_i (data_wdata_i),
      .rsp_cap_i   (rsp_cap[1]),
      .rsp_rdata_i (data_rdata_i),
      .rsp_err_i   (data_err_i),
      .slot_o      (snd)
   );

   assign state = mem_state(req_cnt_q, rsp_cnt_q);

   assign fst_valid_o          = fst.valid;
   assign snd_valid_o          = snd.valid;
   assign fst_we_o             = fst.we;
   assign snd_we_o             = snd.we;
   assign fst_be_o             = fst.be;
   assign snd_be_o             = snd.be;
   assign fst_addr_o           = fst.addr;
   assign snd_addr_o           = snd.addr;
   assign fst_wdata_o          = fst.wdata;
   assign snd_wdata_o          = snd.wdata;
   assign mem_read_fst_rdata_o = fst.rdata;
   assign mem_read_snd_rdata_o = snd.rdata;
   assign fst_err_o            = fst.err;
   assign snd_err_o            = snd.err;
   assign done_o               = (state == StFstDone) || (state == StBothDone);
   assign proto_err_o          = proto_err_q;

endmodule

// File: tb/tb_spec_mem_tracker.sv
// Directed bench for spec_mem_tracker: handshake capture, ordering, clear and
// protocol-violation cases with hand-computed expectations.
module tb_spec_mem_tracker;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic        data_req_i, data_gnt_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;
   logic        data_err_i;
   logic        fst_valid_o, snd_valid_o, fst_we_o, snd_we_o;
   logic [3:0]  fst_be_o, snd_be_o;
   logic [31:0] fst_addr_o, snd_addr_o, fst_wdata_o, snd_wdata_o;
   logic [31:0] mem_read_fst_rdata_o, mem_read_snd_rdata_o;
   logic        fst_err_o, snd_err_o, done_o, proto_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   spec_mem_tracker dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .clear_i              (clear_i),
      .data_req_i           (data_req_i),
      .data_gnt_i           (data_gnt_i),
      .data_we_i            (data_we_i),
      .data_be_i            (data_be_i),
      .data_addr_i          (data_addr_i),
      .data_wdata_i         (data_wdata_i),
      .data_rvalid_i        (data_rvalid_i),
      .data_rdata_i         (data_rdata_i),
      .data_err_i           (data_err_i),
      .fst_valid_o          (fst_valid_o),
      .snd_valid_o          (snd_valid_o),
      .fst_we_o             (fst_we_o),
      .snd_we_o             (snd_we_o),
      .fst_be_o             (fst_be_o),
      .snd_be_o             (snd_be_o),
      .fst_addr_o           (fst_addr_o),
      .snd_addr_o           (snd_addr_o),
      .fst_wdata_o          (fst_wdata_o),
      .snd_wdata_o          (snd_wdata_o),
      .mem_read_fst_rdata_o (mem_read_fst_rdata_o),
      .mem_read_snd_rdata_o (mem_read_snd_rdata_o),
      .fst_err_o            (fst_err_o),
      .snd_err_o            (snd_err_o),
      .done_o               (done_o),
      .proto_err_o          (proto_err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      clear_i       = 1'b0;
      data_req_i    = 1'b0;
      data_gnt_i    = 1'b0;
      data_we_i     = 1'b0;
      data_be_i     = 4'h0;
      data_addr_i   = 32'h0;
      data_wdata_i  = 32'h0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'h0;
      data_err_i    = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic grant(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata);
      data_req_i   = 1'b1;
      data_gnt_i   = 1'b1;
      data_addr_i  = addr;
      data_we_i    = we;
      data_be_i    = be;
      data_wdata_i = wdata;
   endtask

   task automatic rvalid(input logic [31:0] rdata);
      data_rvalid_i = 1'b1;
      data_rdata_i  = rdata;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #2;
      rst_ni = 1'b1;
      step();
   endtask

   task automatic do_clear();
      idle();
      clear_i = 1'b1;
      step();
      idle();
   endtask

   initial begin
      idle();
      rst_ni = 1'b0;
      #3;
      check("rst_fst_valid", 32'(fst_valid_o), 32'h0);
      check("rst_snd_valid", 32'(snd_valid_o), 32'h0);
      check("rst_done", 32'(done_o), 32'h0);
      check("rst_proto", 32'(proto_err_o), 32'h0);
      check("rst_fst_addr", fst_addr_o, 32'h0);
      rst_ni = 1'b1;
      step();

      // Single read; read wdata must be stored as zero.
      grant(32'h0000_1000, 1'b0, 4'hF, 32'h1234_5678);
      step();
      idle();
      check("rd_fst_valid", 32'(fst_valid_o), 32'h1);
      check("rd_fst_addr", fst_addr_o, 32'h0000_1000);
      check("rd_fst_wdata", fst_wdata_o, 32'h0);
      check("rd_done_early", 32'(done_o), 32'h0);
      step();
      rvalid(32'hDEAD_BEEF);
      step();
      idle();
      check("rd_rdata", mem_read_fst_rdata_o, 32'hDEAD_BEEF);
      check("rd_snd_valid", 32'(snd_valid_o), 32'h0);
      check("rd_done", 32'(done_o), 32'h1);
      check("rd_proto", 32'(proto_err_o), 32'h0);

      // Clean clear, then misaligned split write.
      do_clear();
      check("clr_fst_valid", 32'(fst_valid_o), 32'h0);
      check("clr_done", 32'(done_o), 32'h0);
      grant(32'h0000_2000, 1'b1, 4'hC, 32'hAABB_0000);
      step();
      grant(32'h0000_2004, 1'b1, 4'h3, 32'h0000_00CC);
      step();
      idle();
      check("wr_done_pend", 32'(done_o), 32'h0);
      rvalid(32'h0);
      step();
      step();
      idle();
      check("wr_fst_be", 32'(fst_be_o), 32'hC);
      check("wr_fst_wdata", fst_wdata_o, 32'hAABB_0000);
      check("wr_snd_be", 32'(snd_be_o), 32'h3);
      check("wr_snd_addr", snd_addr_o, 32'h0000_2004);
      check("wr_snd_we", 32'(snd_we_o), 32'h1);
      check("wr_done", 32'(done_o), 32'h1);
      check("wr_proto", 32'(proto_err_o), 32'h0);

      // Overlapping grants; second grant coincides with first rvalid.
      do_clear();
      grant(32'h0000_5000, 1'b0, 4'hF, 32'h0);
      step();
      grant(32'h0000_5004, 1'b0, 4'hF, 32'h0);
      rvalid(32'h1111_1111);
      step();
      idle();
      check("b2b_done_pend", 32'(done_o), 32'h0);
      rvalid(32'h2222_2222);
      data_err_i = 1'b1;
      step();
      idle();
      check("b2b_fst_rdata", mem_read_fst_rdata_o, 32'h1111_1111);
      check("b2b_snd_rdata", mem_read_snd_rdata_o, 32'h2222_2222);
      check("b2b_snd_err", 32'(snd_err_o), 32'h1);
      check("b2b_fst_err", 32'(fst_err_o), 32'h0);
      check("b2b_done", 32'(done_o), 32'h1);
      check("b2b_proto", 32'(proto_err_o), 32'h0);

      // Zero-latency response: grant and rvalid for the same slot together.
      do_clear();
      grant(32'h0000_9000, 1'b0, 4'hF, 32'h0);
      rvalid(32'h5A5A_5A5A);
      step();
      idle();
      check("zl_rdata", mem_read_fst_rdata_o, 32'h5A5A_5A5A);
      check("zl_done", 32'(done_o), 32'h1);
      check("zl_proto", 32'(proto_err_o), 32'h0);

      // Clear coinciding with a grant.
      do_clear();
      clear_i = 1'b1;
      grant(32'h0000_4000, 1'b0, 4'hF, 32'h0);
      step();
      idle();
      check("cg_fst_valid", 32'(fst_valid_o), 32'h1);
      check("cg_fst_addr", fst_addr_o, 32'h0000_4000);
      check("cg_snd_valid", 32'(snd_valid_o), 32'h0);
      check("cg_done", 32'(done_o), 32'h0);
      check("cg_proto", 32'(proto_err_o), 32'h0);
      rvalid(32'h0);
      step();
      idle();
      check("cg_done_rsp", 32'(done_o), 32'h1);

      // Spurious rvalid; error is sticky across clear.
      do_clear();
      rvalid(32'h0);
      step();
      idle();
      check("sp_proto", 32'(proto_err_o), 32'h1);
      do_clear();
      check("sp_proto_sticky", 32'(proto_err_o), 32'h1);

      // Third grant is ignored.
      do_reset();
      check("tg_proto_rst", 32'(proto_err_o), 32'h0);
      grant(32'h0000_6000, 1'b0, 4'hF, 32'h0);
      step();
      grant(32'h0000_6004, 1'b0, 4'hF, 32'h0);
      step();
      idle();
      rvalid(32'h0);
      step();
      step();
      idle();
      check("tg_proto_pre", 32'(proto_err_o), 32'h0);
      grant(32'h0000_6008, 1'b0, 4'hF, 32'h0);
      step();
      idle();
      check("tg_proto", 32'(proto_err_o), 32'h1);
      check("tg_snd_addr", snd_addr_o, 32'h0000_6004);
      check("tg_fst_addr", fst_addr_o, 32'h0000_6000);

      // Wrong second granule address, still captured.
      do_reset();
      grant(32'h0000_3000, 1'b0, 4'hF, 32'h0);
      step();
      grant(32'h0000_3008, 1'b0, 4'hF, 32'h0);
      step();
      idle();
      check("ga_proto", 32'(proto_err_o), 32'h1);
      check("ga_snd_addr", snd_addr_o, 32'h0000_3008);

      // Address wrap is legal.
      do_reset();
      grant(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0);
      step();
      grant(32'h0000_0000, 1'b0, 4'hF, 32'h0);
      step();
      idle();
      check("wrap_proto", 32'(proto_err_o), 32'h0);
      check("wrap_snd_valid", 32'(snd_valid_o), 32'h1);

      // we mismatch between granules.
      do_reset();
      grant(32'h0000_A000, 1'b1, 4'hF, 32'h1);
      step();
      grant(32'h0000_A004, 1'b0, 4'hF, 32'h0);
      step();
      idle();
      check("we_proto", 32'(proto_err_o), 32'h1);
      check("we_snd_wdata", snd_wdata_o, 32'h0);

      // Clear with a response outstanding.
      do_reset();
      grant(32'h0000_7000, 1'b0, 4'hF, 32'h0);
      step();
      idle();
      check("co_proto_pre", 32'(proto_err_o), 32'h0);
      do_clear();
      check("co_proto", 32'(proto_err_o), 32'h1);
      check("co_fst_valid", 32'(fst_valid_o), 32'h0);

      // Asynchronous reset mid-transaction.
      do_reset();
      grant(32'h0000_8000, 1'b0, 4'hF, 32'h0);
      step();
      idle();
      check("ar_fst_valid_pre", 32'(fst_valid_o), 32'h1);
      rst_ni = 1'b0;
      #1;
      check("ar_fst_valid", 32'(fst_valid_o), 32'h0);
      check("ar_fst_addr", fst_addr_o, 32'h0);
      check("ar_proto", 32'(proto_err_o), 32'h0);
      rst_ni = 1'b1;
      rvalid(32'h0);
      step();
      idle();
      check("ar_rvalid_proto", 32'(proto_err_o), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
